// File: rtl/mcl86_mem_pkg.sv
// rtl/mcl86_mem_pkg.sv - Shared types and widths for the byte-wide SRAM controller
package mcl86_mem_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_e;

  // The data bus is driven for the whole write window, including setup and hold.
  function automatic logic drives_bus(input state_e s);
    return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - CPU request port and SRAM pin bundle for sram_ctrl
interface sram_ctrl_if;
  import mcl86_mem_pkg::*;

  logic [ADDR_W-1:0] iCpuAddr;
  logic [DATA_W-1:0] iCpuDataW;
  logic              iCpuR;
  logic              iCpuW;
  logic [DATA_W-1:0] oCpuDataR;
  logic              oCpuReady;
  logic [ADDR_W-1:0] oSramAddr;
  logic [DATA_W-1:0] oSramDataOut;
  logic              oSramDataOe;
  logic [DATA_W-1:0] iSramDataIn;
  logic              oSramWe;

  modport master (
    output iCpuAddr, iCpuDataW, iCpuR, iCpuW, iSramDataIn,
    input  oCpuDataR, oCpuReady, oSramAddr, oSramDataOut, oSramDataOe, oSramWe
  );

  modport slave (
    input  iCpuAddr, iCpuDataW, iCpuR, iCpuW, iSramDataIn,
    output oCpuDataR, oCpuReady, oSramAddr, oSramDataOut, oSramDataOe, oSramWe
  );

endinterface

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - Byte-wide asynchronous SRAM controller with fixed read/write wait states
module sram_ctrl
  import mcl86_mem_pkg::*;
#(
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 2
) (
  input logic        iClk,
  input logic        iRst,
  sram_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.iCpuW || bus.iCpuR) begin
          addr_d  = bus.iCpuAddr;
          wdata_d = bus.iCpuDataW;
          // A simultaneous read and write resolves to the write.
          if (bus.iCpuW) begin
            state_d = WR_SETUP;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = cnt_t'(READ_WAIT - 1);
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          rdata_d = bus.iSramDataIn;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = cnt_t'(WRITE_WAIT - 1);
      end
      WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      WR_HOLD: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // WE is registered from the next state so it can only rise after address and data settled.
    we_d = (state_d == WR_PULSE);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
    end
  end

  assign bus.oSramAddr    = addr_q;
  assign bus.oSramDataOut = wdata_q;
  assign bus.oSramWe      = we_q;
  assign bus.oSramDataOe  = drives_bus(state_q);
  assign bus.oCpuReady    = (state_q == DONE);
  assign bus.oCpuDataR    = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - Self-checking bench for sram_ctrl against a transaction-level model
module tb_sram_ctrl;

  localparam int RW = 2;
  localparam int WW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_ctrl_if bus ();

  sram_ctrl #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  logic [7:0] env_mem [logic [19:0]];
  logic [7:0] ref_mem [logic [19:0]];

  bit         t_valid = 1'b0;
  bit         t_wr    = 1'b0;
  int         t_a     = 0;
  int         t_done  = 0;
  logic [19:0] t_addr = '0;
  logic [7:0]  t_data = '0;
  int         next_accept = 32'h4000_0000;
  logic [19:0] exp_addr  = '0;
  logic [7:0]  exp_wdata = '0;
  logic [7:0]  exp_rdata = '0;

  int we_seen  = 0;
  int oe_seen  = 0;
  int rdy_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [19:0] a);
    return a[7:0] ^ a[19:12] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] env_read(input logic [19:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] ref_read(input logic [19:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  // Reference model: schedules each accepted transaction from its accept edge using the latency rules.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (t_valid && t_wr && cyc == t_a + 2) ref_mem[t_addr] = t_data;
      if (rst) begin
        t_valid     = 1'b0;
        exp_addr    = '0;
        exp_wdata   = '0;
        exp_rdata   = '0;
        next_accept = cyc + 1;
      end else begin
        if (t_valid && !t_wr && cyc == t_done) exp_rdata = ref_read(t_addr);
        if (cyc >= next_accept && (bus.iCpuR || bus.iCpuW)) begin
          t_valid     = 1'b1;
          t_wr        = bus.iCpuW;
          t_a         = cyc;
          t_addr      = bus.iCpuAddr;
          t_data      = bus.iCpuDataW;
          exp_addr    = bus.iCpuAddr;
          exp_wdata   = bus.iCpuDataW;
          t_done      = bus.iCpuW ? cyc + WW + 2 : cyc + RW;
          next_accept = t_done + 2;
        end
      end
    end
  end

  // Per-cycle compare plus the SRAM device model.
  initial begin
    bit e_rdy, e_we, e_oe;
    bus.iSramDataIn = '0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_rdy = t_valid && (cyc == t_done);
        e_we  = t_valid && t_wr && (cyc >= t_a + 1) && (cyc <= t_a + WW);
        e_oe  = t_valid && t_wr && (cyc >= t_a) && (cyc <= t_a + WW + 1);
        chk("ready", 32'(bus.oCpuReady), 32'(e_rdy));
        chk("we",    32'(bus.oSramWe),   32'(e_we));
        chk("oe",    32'(bus.oSramDataOe), 32'(e_oe));
        chk("addr",  32'(bus.oSramAddr), 32'(exp_addr));
        chk("dout",  32'(bus.oSramDataOut), 32'(exp_wdata));
        chk("rdata", 32'(bus.oCpuDataR), 32'(exp_rdata));
      end
      if (bus.oCpuReady)   rdy_seen = rdy_seen + 1;
      if (bus.oSramWe)     we_seen  = we_seen + 1;
      if (bus.oSramDataOe) oe_seen  = oe_seen + 1;
      if (bus.oSramWe) env_mem[bus.oSramAddr] = bus.oSramDataOut;
      bus.iSramDataIn = env_read(bus.oSramAddr);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // mode: 0 plain, 1 scramble inputs while busy, 2 force address to 0 while busy, 3 present a read at DONE
  task automatic run_txn(input bit r, input bit w, input logic [19:0] a, input logic [7:0] d,
                         input int mode, output int lat, output int done_c);
    int start;
    bit got;
    start  = cyc;
    got    = 1'b0;
    lat    = 0;
    done_c = cyc;
    bus.iCpuR = r;
    bus.iCpuW = w;
    bus.iCpuAddr  = a;
    bus.iCpuDataW = d;
    for (int n = 0; n < 64 && !got; n++) begin
      step();
      if (bus.oCpuReady) begin
        got    = 1'b1;
        lat    = cyc - start;
        done_c = cyc;
      end else if (mode == 1 && $urandom_range(0, 2) == 0) begin
        bus.iCpuAddr  = 20'($urandom);
        bus.iCpuDataW = 8'($urandom);
      end else if (mode == 2) begin
        bus.iCpuAddr = '0;
      end
    end
    if (!got) chk("ready_timeout", 32'(bus.oCpuReady), 32'd1);
    if (mode == 3) begin
      bus.iCpuR = 1'b1;
      bus.iCpuW = 1'b0;
    end else begin
      bus.iCpuR = 1'b0;
      bus.iCpuW = 1'b0;
    end
  endtask

  initial begin
    int lat, dc, d1, w0, o0, r0;
    logic [19:0] pool [12];
    logic [19:0] key;
    bit saw;

    bus.iCpuR = 1'b0;
    bus.iCpuW = 1'b0;
    bus.iCpuAddr  = 20'h5_5555;
    bus.iCpuDataW = 8'hEE;
    key = 20'h12345;
    env_mem[key] = 8'hA5;
    ref_mem[key] = 8'hA5;

    @(posedge clk);
    #2;
    chk_en = 1'b1;
    repeat (2) step();
    chk("rst_addr",  32'(bus.oSramAddr), 32'h0);
    chk("rst_dout",  32'(bus.oSramDataOut), 32'h0);
    chk("rst_we",    32'(bus.oSramWe), 32'h0);
    chk("rst_oe",    32'(bus.oSramDataOe), 32'h0);
    chk("rst_ready", 32'(bus.oCpuReady), 32'h0);
    chk("rst_rdata", 32'(bus.oCpuDataR), 32'h0);

    // Read issued in the same slot reset drops: accepted on the first edge.
    w0 = we_seen; o0 = oe_seen;
    rst = 1'b0;
    run_txn(1'b1, 1'b0, 20'h12345, 8'h00, 0, lat, dc);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_data", 32'(bus.oCpuDataR), 32'hA5);
    step();
    chk("rd_we_cycles", 32'(we_seen - w0), 32'd0);
    chk("rd_oe_cycles", 32'(oe_seen - o0), 32'd0);

    w0 = we_seen; o0 = oe_seen; r0 = rdy_seen;
    run_txn(1'b0, 1'b1, 20'hFFFFF, 8'h3C, 0, lat, dc);
    step();
    chk("wr_latency", 32'(lat), 32'd5);
    chk("wr_we_cycles", 32'(we_seen - w0), 32'd2);
    chk("wr_oe_cycles", 32'(oe_seen - o0), 32'd4);
    chk("wr_ready_pulses", 32'(rdy_seen - r0), 32'd1);
    chk("wr_mem", 32'(env_read(20'hFFFFF)), 32'h3C);

    w0 = we_seen; r0 = rdy_seen;
    run_txn(1'b1, 1'b1, 20'h00010, 8'h77, 0, lat, dc);
    step();
    chk("both_latency", 32'(lat), 32'd5);
    chk("both_we_cycles", 32'(we_seen - w0), 32'd2);
    chk("both_ready_pulses", 32'(rdy_seen - r0), 32'd1);
    chk("both_mem", 32'(env_read(20'h00010)), 32'h77);

    o0 = oe_seen; r0 = rdy_seen;
    run_txn(1'b0, 1'b1, 20'h40003, 8'hC3, 3, lat, d1);
    step();
    chk("b2b_idle_oe", 32'(bus.oSramDataOe), 32'h0);
    run_txn(1'b1, 1'b0, 20'h40003, 8'h00, 0, lat, dc);
    chk("b2b_rdata", 32'(bus.oCpuDataR), 32'hC3);
    chk("b2b_spacing", 32'(dc - d1), 32'd4);
    step();
    chk("b2b_oe_cycles", 32'(oe_seen - o0), 32'd4);
    chk("b2b_ready_pulses", 32'(rdy_seen - r0), 32'd2);

    // Reset lands while WE is high.
    r0 = rdy_seen;
    saw = 1'b0;
    bus.iCpuW = 1'b1;
    bus.iCpuAddr  = 20'h40005;
    bus.iCpuDataW = 8'h5E;
    for (int n = 0; n < 20 && !saw; n++) begin
      step();
      saw = bus.oSramWe;
    end
    chk("abort_we_reached", 32'(bus.oSramWe), 32'h1);
    rst = 1'b1;
    bus.iCpuW = 1'b0;
    step();
    chk("abort_we_off", 32'(bus.oSramWe), 32'h0);
    rst = 1'b0;
    repeat (6) step();
    chk("abort_no_ready", 32'(rdy_seen - r0), 32'd0);
    run_txn(1'b1, 1'b0, 20'h12345, 8'h00, 0, lat, dc);
    chk("abort_rd_latency", 32'(lat), 32'd3);
    chk("abort_rd_data", 32'(bus.oCpuDataR), 32'hA5);
    step();

    run_txn(1'b1, 1'b0, 20'h0ABCD, 8'h11, 2, lat, dc);
    chk("hold_addr", 32'(bus.oSramAddr), 32'h0ABCD);
    chk("hold_latency", 32'(lat), 32'd3);
    step();

    for (int i = 0; i < 8; i++) pool[i] = 20'h40000 + 20'(i);
    pool[8] = 20'h00000; pool[9] = 20'hFFFFF; pool[10] = 20'h00010; pool[11] = 20'h0ABCD;
    for (int i = 0; i < 80; i++) begin
      int kind, gap;
      bit r, w;
      kind = $urandom_range(0, 3);
      r = (kind != 1);
      w = (kind == 1) || (kind == 2);
      gap = $urandom_range(0, 2);
      run_txn(r, w, pool[$urandom_range(0, 11)], 8'($urandom), $urandom_range(0, 1), lat, dc);
      chk("rand_latency", 32'(lat), w ? 32'(WW + 3) : 32'(RW + 1));
      repeat (1 + gap) step();
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter READ_WAIT, default 2: SRAM read access cycles, legal range 1..15.
REQ-002 SHALL have parameter WRITE_WAIT, default 2: WE pulse width in cycles, legal range 1..15.
REQ-003 SHALL have one clock and a synchronous, active-high reset: iClk input 1, system clock; iRst input 1, synchronous active-high reset.
REQ-004 iCpuAddr  input  20  CPU byte address.
REQ-005 iCpuDataW  input  8  CPU write data.
REQ-006 iCpuR  input  1  read request; held until oCpuReady.
REQ-007 iCpuW  input  1  write request; held until oCpuReady.
REQ-008 oCpuDataR  output  8  read data; valid while oCpuReady=1 and held until the next read completes.
REQ-009 oCpuReady  output  1  single-cycle completion pulse.
REQ-010 oSramAddr  output  20  SRAM address (registered).
REQ-011 oSramDataOut  output  8  SRAM write data (registered).
REQ-012 oSramDataOe  output  1  data-bus drive enable; top level tristates ioSramData with it.
REQ-013 iSramDataIn  input  8  SRAM data bus as read back.
REQ-014 oSramWe  output  1  SRAM write enable, active high (registered).

Function
REQ-015 SHALL implement FSM states IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-016 IDLE SHALL accept a request on any edge where iCpuR or iCpuW is 1, latching iCpuAddr into oSramAddr and iCpuDataW into oSramDataOut.
REQ-017 If iCpuR and iCpuW are both 1 in IDLE, the write SHALL be taken and the read ignored.
REQ-018 Read: IDLE->RD_WAIT, remaining READ_WAIT cycles (down-counter), then ->DONE, capturing iSramDataIn into oCpuDataR on the RD_WAIT->DONE edge.
REQ-019 Read: oSramWe=0 and oSramDataOe=0 throughout.
REQ-020 Write: IDLE->WR_SETUP (1 cycle; oSramDataOe=1, oSramWe=0)->WR_PULSE (WRITE_WAIT cycles; oSramDataOe=1, oSramWe=1)->WR_HOLD (1 cycle; oSramDataOe=1, oSramWe=0)->DONE.
REQ-021 oSramWe SHALL never be 1 in a cycle where oSramAddr or oSramDataOut differs from its value in the previous cycle.
REQ-022 DONE SHALL last exactly 1 cycle with oCpuReady=1, then return unconditionally to IDLE.
REQ-023 Read latency, from accept edge to the ready cycle, SHALL be READ_WAIT+1 cycles.
REQ-024 Write latency, from accept edge to the ready cycle, SHALL be WRITE_WAIT+3 cycles.
REQ-025 A request still asserted in the IDLE cycle after DONE SHALL start a new transaction; the CPU drops its request in the DONE cycle to avoid a repeat.
REQ-026 Request changes while not in IDLE SHALL be ignored; the latched address and data stay stable for the whole transaction.
REQ-027 oSramDataOe SHALL be 0 in IDLE, DONE and RD_WAIT, giving at least one turnaround cycle between a write and a following read.
REQ-028 Minimum request-to-request spacing SHALL be the ready cycle plus one IDLE cycle.

Reset
REQ-029 While iRst=1: state=IDLE, counter=0, oSramWe=0, oSramDataOe=0, oCpuReady=0, oSramAddr=0, oSramDataOut=0, oCpuDataR=0.
REQ-030 Reset asserted mid-transaction SHALL abort it on that edge with no ready pulse; oSramWe=0 on the following cycle.
REQ-031 The first request SHALL be accepted on the first edge after iRst is deasserted.

Structure
REQ-032 State encoding and the 4-bit wait-counter width SHALL live in shared package mcl86_mem_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; tristate buffers SHALL stay in top-level wrappers.

Verification
REQ-034 The bench SHALL cover read at addr 0x12345, SRAM model returning 0xA5, READ_WAIT=2 -> oCpuReady high 3 cycles after accept, oCpuDataR=0xA5, oSramWe and oSramDataOe low throughout.
REQ-035 The bench SHALL cover write 0x3C to 0xFFFFF, WRITE_WAIT=2 -> oSramWe high exactly 2 cycles, oSramDataOe high 4 cycles, ready at cycle 5, model holds 0x3C at 0xFFFFF.
REQ-036 The bench SHALL cover iCpuR=iCpuW=1 at 0x00010, data 0x77 -> write sequence only, model[0x00010]=0x77, one ready pulse.
REQ-037 The bench SHALL cover write then read of the same address back-to-back, request held through DONE -> second transaction starts in the IDLE cycle, read returns the written byte, oSramDataOe=0 for at least 1 cycle between them.
REQ-038 The bench SHALL cover iRst pulsed during WR_PULSE -> oSramWe=0 on the next cycle, no oCpuReady, and the next read completes normally.
REQ-039 The bench SHALL cover iCpuAddr changed to 0x00000 during RD_WAIT of a read to 0x0ABCD -> oSramAddr stays 0x0ABCD until DONE.
